// File: rtl/pe_bcast_pkg.sv
// pe_bcast_pkg: shared types and helpers for the element-replication PE.
//   mode_e   : per-beat element rebuild mode
//   src_elem : returns the source element index feeding output element e
package pe_bcast_pkg;

  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_REP_LO  = 2'd1,
    MODE_REP_SEL = 2'd2,
    MODE_REV     = 2'd3
  } mode_e;

  // elems is always a power of two, so masking keeps sel in range even when
  // the SEL port is wider than needed (single-element words).
  function automatic int src_elem(input mode_e mode, input int sel, input int e, input int elems);
    int idx;
    case (mode)
      MODE_PASS:    idx = e;
      MODE_REP_LO:  idx = 0;
      MODE_REP_SEL: idx = sel & (elems - 1);
      MODE_REV:     idx = elems - 1 - e;
      default:      idx = e;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/pe_bcast_skid.sv
// pe_bcast_skid: 2-entry valid/ready buffer (output register + 1-entry skid).
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_data/i_vld/o_rdy  : upstream side; o_rdy is registered (= skid empty)
//   o_data/o_vld/i_rdy  : downstream side; o_data held while o_vld && !i_rdy
module pe_bcast_skid #(
  parameter int DW = 512
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [DW-1:0] i_data,
  input  logic          i_vld,
  output logic          o_rdy,
  output logic [DW-1:0] o_data,
  output logic          o_vld,
  input  logic          i_rdy
);

  logic [DW-1:0] r_out_data;
  logic [DW-1:0] r_skid_data;
  logic          r_out_vld;
  logic          r_skid_vld;
  logic          w_acc;
  logic          w_xfer;

  assign w_acc  = i_vld && !r_skid_vld;
  assign w_xfer = r_out_vld && i_rdy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_vld   <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_out_data  <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_xfer || !r_out_vld) begin
        // Output register is free at this edge: the older skid beat has
        // priority; otherwise a new beat lands directly (no bubble).
        if (r_skid_vld) begin
          r_out_data <= r_skid_data;
          r_out_vld  <= 1'b1;
          r_skid_vld <= 1'b0;
        end else begin
          r_out_vld <= w_acc;
          if (w_acc) r_out_data <= i_data;
        end
      end else if (w_acc) begin
        // Output stalled: park the accepted beat; o_rdy drops next cycle.
        r_skid_data <= i_data;
        r_skid_vld  <= 1'b1;
      end
    end
  end

  assign o_rdy  = !r_skid_vld;
  assign o_vld  = r_out_vld;
  assign o_data = r_out_data;

endmodule

// File: rtl/pe_bcast.sv
// pe_bcast: registered element-replication PE across LANES lane words.
//   CLK, RST_N          : clock, asynchronous active-low reset
//   PECPIN, MODE, SEL   : input lane words and per-beat rebuild mode / element index
//   D_VALID / D_READY   : input handshake (D_READY registered)
//   PECPOUT             : transformed output lane words
//   Q_VALID / Q_READY   : output handshake
//   BEAT_CNT            : number of output transfers, wraps at 2^32
module pe_bcast
  import pe_bcast_pkg::*;
#(
  parameter  int LANES  = 8,
  parameter  int WORD_W = 64,
  parameter  int ELEM_W = 32,
  localparam int ELEMS  = WORD_W / ELEM_W,
  localparam int SEL_W  = (ELEMS > 1) ? $clog2(ELEMS) : 1
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [LANES-1:0][WORD_W-1:0]  PECPIN,
  input  mode_e                         MODE,
  input  logic [SEL_W-1:0]              SEL,
  input  logic                          D_VALID,
  output logic                          D_READY,
  output logic [LANES-1:0][WORD_W-1:0]  PECPOUT,
  output logic                          Q_VALID,
  input  logic                          Q_READY,
  output logic [31:0]                   BEAT_CNT
);

  if ((WORD_W % ELEM_W) != 0 || (ELEMS & (ELEMS - 1)) != 0) begin : g_param_err
    $error("pe_bcast: WORD_W must be a multiple of ELEM_W with a power-of-two element count");
  end

  function automatic logic [WORD_W-1:0] elem_xform(input logic [WORD_W-1:0] word,
                                                   input mode_e mode,
                                                   input logic [SEL_W-1:0] sel);
    logic [WORD_W-1:0] res;
    res = '0;
    for (int e = 0; e < ELEMS; e++) begin
      res[e*ELEM_W +: ELEM_W] = word[src_elem(mode, int'(sel), e, ELEMS)*ELEM_W +: ELEM_W];
    end
    return res;
  endfunction

  logic [LANES-1:0][WORD_W-1:0] w_xform;
  logic [31:0]                  r_beat_cnt;

  // Transform on the input side so the skid only ever holds finished beats.
  always_comb begin
    w_xform = '0;
    for (int l = 0; l < LANES; l++) begin
      w_xform[l] = elem_xform(PECPIN[l], MODE, SEL);
    end
  end

  pe_bcast_skid #(
    .DW (LANES * WORD_W)
  ) u_skid (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_data  (w_xform),
    .i_vld   (D_VALID),
    .o_rdy   (D_READY),
    .o_data  (PECPOUT),
    .o_vld   (Q_VALID),
    .i_rdy   (Q_READY)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_beat_cnt <= '0;
    end else if (Q_VALID && Q_READY) begin
      r_beat_cnt <= r_beat_cnt + 32'd1;
    end
  end

  assign BEAT_CNT = r_beat_cnt;

endmodule

// File: tb/tb_pe_bcast.sv
module tb_pe_bcast;
  import pe_bcast_pkg::*;

  localparam int L = 8;
  localparam int W = 64;
  typedef logic [L-1:0][W-1:0] bus_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter DUT
  logic        rst_n;
  bus_t        pin, pout;
  mode_e       mode;
  logic        sel;
  logic        dv, dr, qv, qr;
  logic [31:0] cnt;
  logic        qr_fixed, qr_rand, qr_rnd_en;

  assign qr = qr_rnd_en ? qr_rand : qr_fixed;

  // ELEM_W=16 DUT
  bus_t        pin1, pout1;
  mode_e       mode1;
  logic [1:0]  sel1;
  logic        dv1, dr1, qv1;
  logic        qr1;
  logic [31:0] cnt1;

  pe_bcast dut (
    .CLK(clk), .RST_N(rst_n), .PECPIN(pin), .MODE(mode), .SEL(sel),
    .D_VALID(dv), .D_READY(dr), .PECPOUT(pout), .Q_VALID(qv), .Q_READY(qr),
    .BEAT_CNT(cnt)
  );

  pe_bcast #(.LANES(8), .WORD_W(64), .ELEM_W(16)) dut16 (
    .CLK(clk), .RST_N(rst_n), .PECPIN(pin1), .MODE(mode1), .SEL(sel1),
    .D_VALID(dv1), .D_READY(dr1), .PECPOUT(pout1), .Q_VALID(qv1), .Q_READY(qr1),
    .BEAT_CNT(cnt1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model for 32-bit elements in 64-bit words (two elements).
  function automatic bus_t model(input bus_t d, input mode_e m, input logic s);
    bus_t r;
    for (int l = 0; l < L; l++) begin
      logic [31:0] lo, hi;
      lo = d[l][31:0];
      hi = d[l][63:32];
      case (m)
        MODE_PASS:    r[l] = {hi, lo};
        MODE_REP_LO:  r[l] = {lo, lo};
        MODE_REP_SEL: r[l] = s ? {hi, hi} : {lo, lo};
        default:      r[l] = {lo, hi};
      endcase
    end
    return r;
  endfunction

  function automatic bus_t rnd_bus();
    logic [511:0] t;
    bus_t r;
    for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom;
    r = t;
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    qr_rand = 1'($urandom_range(0, 1));
  end

  // Scoreboard monitor: sampled on the falling edge, describing what the
  // next rising edge will transfer / accept.
  bus_t q[$];
  bit   mon_en     = 1'b0;
  bit   prev_stall = 1'b0;
  bus_t prev_data;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("d_ready_vs_occupancy", dr, q.size() < 2);
      chk("q_valid_vs_occupancy", qv, q.size() != 0);
      if (prev_stall) begin
        chk("stall_q_valid_held", qv, 1'b1);
        chk("stall_data_stable", pout, prev_data);
      end
      if (qv && qr) begin
        if (q.size() == 0) chk("spurious_output", 1'b1, 1'b0);
        else chk("out_data_order", pout, q.pop_front());
      end
      if (dv && dr) q.push_back(model(pin, mode, sel));
      prev_stall = qv && !qr;
      prev_data  = pout;
    end
  end

  task automatic send(input bus_t d, input mode_e m, input logic s, output int waited);
    int t;
    bit acc;
    t   = 0;
    acc = 1'b0;
    pin = d; mode = m; sel = s; dv = 1'b1;
    while (!acc && t < 500) begin
      @(negedge clk);
      acc = dr;
      @(posedge clk);
      #1;
      if (!acc) t++;
    end
    dv = 1'b0;
    if (!acc) chk("send_timeout", 1'b0, 1'b1);
    waited = t;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic step16(input mode_e m, input logic [1:0] s);
    mode1 = m; sel1 = s; dv1 = 1'b1;
    @(posedge clk);
    #1;
    dv1 = 1'b0;
  endtask

  initial begin
    int   w, stalls;
    logic [31:0] c0;
    bus_t d, b1, b2, b3;

    rst_n = 1'b0; dv = 1'b0; pin = '0; mode = MODE_PASS; sel = 1'b0;
    qr_fixed = 1'b1; qr_rnd_en = 1'b0; qr_rand = 1'b0;
    pin1 = '0; mode1 = MODE_PASS; sel1 = 2'd0; dv1 = 1'b0; qr1 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_q_valid", qv, 1'b0);
    chk("rst_beat_cnt", cnt, 32'd0);
    chk("rst_pecpout", pout, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_d_ready", dr, 1'b1);
    chk("rst_q_valid_after", qv, 1'b0);
    mon_en = 1'b1;

    // replicate low element, one-cycle latency
    d = '0;
    d[0] = 64'h1111_2222_3333_4444;
    send(d, MODE_REP_LO, 1'b0, w);
    chk("t1_latency_valid", qv, 1'b1);
    chk("t1_lane0", pout[0], 64'h3333_4444_3333_4444);
    chk("t1_lane1", pout[1], 64'h0);
    drain();
    chk("t1_cnt", cnt, 32'd1);

    // 16-bit elements
    pin1 = {8{64'hAAAA_BBBB_CCCC_DDDD}};
    step16(MODE_REP_SEL, 2'd2);
    chk("t2_sel_valid", qv1, 1'b1);
    chk("t2_sel_lane0", pout1[0], 64'hBBBB_BBBB_BBBB_BBBB);
    chk("t2_sel_lane7", pout1[7], 64'hBBBB_BBBB_BBBB_BBBB);
    step16(MODE_REV, 2'd0);
    chk("t2_rev_lane0", pout1[0], 64'hDDDD_CCCC_BBBB_AAAA);
    step16(MODE_PASS, 2'd3);
    chk("t2_pass_lane3", pout1[3], 64'hAAAA_BBBB_CCCC_DDDD);
    step16(MODE_REP_LO, 2'd1);
    chk("t2_replo_lane5", pout1[5], 64'hDDDD_DDDD_DDDD_DDDD);
    step16(MODE_REP_SEL, 2'd3);
    chk("t2_sel3_lane0", pout1[0], 64'hAAAA_AAAA_AAAA_AAAA);

    // 100-beat stream at full rate
    c0 = cnt;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      send(rnd_bus(), mode_e'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), w);
      stalls += w;
    end
    chk("t3_no_stall", stalls, 0);
    drain();
    chk("t3_cnt_delta", cnt - c0, 32'd100);

    // random back-pressure
    c0 = cnt;
    qr_rnd_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(rnd_bus(), mode_e'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), w);
    end
    qr_rnd_en = 1'b0;
    qr_fixed  = 1'b1;
    drain();
    chk("t4_cnt_delta", cnt - c0, 32'd1000);

    // fill out reg + skid with downstream stalled
    c0 = cnt;
    qr_fixed = 1'b0;
    b1 = rnd_bus(); b2 = rnd_bus(); b3 = rnd_bus();
    send(b1, MODE_PASS, 1'b0, w);
    chk("t5_b1_wait", w, 0);
    send(b2, MODE_REV, 1'b0, w);
    chk("t5_b2_wait", w, 0);
    pin = b3; mode = MODE_REP_SEL; sel = 1'b1; dv = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_d_ready_low", dr, 1'b0);
    chk("t5_head_data", pout, model(b1, MODE_PASS, 1'b0));
    chk("t5_cnt_held", cnt, c0);
    qr_fixed = 1'b1;
    send(b3, MODE_REP_SEL, 1'b1, w);
    drain();
    chk("t5_cnt_delta", cnt - c0, 32'd3);

    // reset with skid full
    qr_fixed = 1'b0;
    send(rnd_bus(), MODE_PASS, 1'b0, w);
    send(rnd_bus(), MODE_REV, 1'b0, w);
    chk("t6_skid_full", dr, 1'b0);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("t6_q_valid_rst", qv, 1'b0);
    chk("t6_cnt_rst", cnt, 32'd0);
    chk("t6_pout_rst", pout, '0);
    q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_d_ready_after", dr, 1'b1);
    chk("t6_q_valid_after", qv, 1'b0);
    qr_fixed = 1'b1;
    mon_en   = 1'b1;
    send(rnd_bus(), MODE_REP_LO, 1'b0, w);
    drain();
    chk("t6_cnt_after", cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
